// File: rtl/image_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// image_loader_pkg -- shared geometry, framing constants and FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package image_loader_pkg;

  localparam int         IMG_W          = 28;
  localparam int         IMG_H          = 28;
  localparam int         NUM_PIXELS     = IMG_W * IMG_H;
  localparam logic [7:0] SYNC_BYTE      = 8'hAA;
  localparam int         PIX_SHIFT      = 1;
  localparam int         TIMEOUT_CYCLES = 1000000;

  typedef enum logic [2:0] {
    S_WAIT_SYNC = 3'd0,
    S_RECV      = 3'd1,
    S_CLR       = 3'd2,
    S_START     = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/timeout_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timeout_counter -- idle-cycle counter with clear, enable and terminal pulse
// Rev 1.0
// ---------------------------------------------------------------------------
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  import image_loader_pkg::*;

  localparam int            CW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] C_TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the idle cycle that would take the count past its terminal value.
  assign tc_o = en_i && !clr_i && (cnt_q == C_TERM);

endmodule
`default_nettype wire

// File: rtl/image_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// image_loader -- byte-stream frame receiver feeding image RAM and inference
// Rev 1.0
// ---------------------------------------------------------------------------
module image_loader #(
  parameter logic [7:0] SYNC_BYTE      = image_loader_pkg::SYNC_BYTE,
  parameter int         NUM_PIXELS     = image_loader_pkg::NUM_PIXELS,
  parameter int         TIMEOUT_CYCLES = image_loader_pkg::TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       img_we,
  output logic [9:0] img_waddr,
  output logic [7:0] img_wdata,
  output logic       inf_rst,
  output logic       inf_start,
  input  logic       inf_done,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] frame_count
);
  import image_loader_pkg::*;

  localparam int            AW         = 10;
  localparam logic [AW-1:0] C_LAST_IDX = AW'(NUM_PIXELS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          img_we_q, img_we_d;
  logic [AW-1:0] img_waddr_q, img_waddr_d;
  logic [7:0]    img_wdata_q, img_wdata_d;
  logic          inf_rst_q, inf_rst_d;
  logic          inf_start_q, inf_start_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic          busy_q;
  logic          tmo_clr, tmo_en, tmo_tc;

  // Any received byte or leaving RECV restarts the idle count.
  assign tmo_clr = (state_q != S_RECV) || rx_valid;
  assign tmo_en  = (state_q == S_RECV) && !rx_valid;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    img_we_d      = 1'b0;
    img_waddr_d   = img_waddr_q;
    img_wdata_d   = img_wdata_q;
    inf_rst_d     = 1'b0;
    inf_start_d   = 1'b0;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      S_WAIT_SYNC: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_RECV;
          idx_d   = '0;
        end
      end
      S_RECV: begin
        // Inside a frame every byte is pixel data, including SYNC_BYTE.
        if (rx_valid) begin
          img_we_d    = 1'b1;
          img_waddr_d = idx_q;
          img_wdata_d = rx_data >> PIX_SHIFT;
          idx_d       = idx_q + 1'b1;
          if (idx_q == C_LAST_IDX) begin
            state_d = S_CLR;
          end
        end else if (tmo_tc) begin
          frame_err_d = 1'b1;
          state_d     = S_WAIT_SYNC;
        end
      end
      S_CLR: begin
        inf_rst_d = 1'b1;
        state_d   = S_START;
      end
      S_START: begin
        inf_start_d = 1'b1;
        state_d     = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (inf_done) begin
          frame_count_d = frame_count_q + 1'b1;
          state_d       = S_WAIT_SYNC;
        end
      end
      default: state_d = S_WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_WAIT_SYNC;
      idx_q         <= '0;
      img_we_q      <= 1'b0;
      img_waddr_q   <= '0;
      img_wdata_q   <= '0;
      inf_rst_q     <= 1'b0;
      inf_start_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      img_we_q      <= img_we_d;
      img_waddr_q   <= img_waddr_d;
      img_wdata_q   <= img_wdata_d;
      inf_rst_q     <= inf_rst_d;
      inf_start_q   <= inf_start_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
      busy_q        <= (state_d != S_WAIT_SYNC);
    end
  end

  assign img_we      = img_we_q;
  assign img_waddr   = img_waddr_q;
  assign img_wdata   = img_wdata_q;
  assign inf_rst     = inf_rst_q;
  assign inf_start   = inf_start_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_image_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_image_loader -- randomized scoreboard bench for image_loader
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_image_loader;

  localparam int         NPIX = 784;
  localparam int         TMO  = 100;
  localparam logic [7:0] SYNC = 8'hAA;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       inf_done = 1'b0;
  logic       img_we, inf_rst, inf_start, busy, frame_err;
  logic [9:0] img_waddr;
  logic [7:0] img_wdata, frame_count;

  image_loader #(
    .SYNC_BYTE      (SYNC),
    .NUM_PIXELS     (NPIX),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .img_we      (img_we),
    .img_waddr   (img_waddr),
    .img_wdata   (img_wdata),
    .inf_rst     (inf_rst),
    .inf_start   (inf_start),
    .inf_done    (inf_done),
    .busy        (busy),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    int         edge_n;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  exp_fc = 0;
  int  phase = 0;        // 0: hunting for sync, 1: collecting pixels, 2: frame handed to inference
  int  pix = 0;
  int  last_byte_edge = 0;
  int  last_we_edge = -10;
  int  rst_edge = -10;
  int  err_edge = -10;
  int  n_rst = 0;
  int  n_start = 0;
  int  n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour per received byte: sync hunt, pixel capture with >>1 scaling, drop while inferring.
  function automatic void model_byte(input logic [7:0] b, input int edge_n);
    wr_t w;
    case (phase)
      0: if (b == SYNC) begin
        phase = 1;
        pix   = 0;
      end
      1: begin
        w.addr   = 10'(pix);
        w.data   = b / 2;
        w.edge_n = edge_n;
        exp_q.push_back(w);
        pix++;
        if (pix == NPIX) phase = 2;
      end
      default: ;
    endcase
  endfunction

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    last_byte_edge = cyc + 1;
    model_byte(b, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_img_we"},      img_we,      0);
    chk({tag, "_img_waddr"},   img_waddr,   0);
    chk({tag, "_img_wdata"},   img_wdata,   0);
    chk({tag, "_inf_rst"},     inf_rst,     0);
    chk({tag, "_inf_start"},   inf_start,   0);
    chk({tag, "_frame_err"},   frame_err,   0);
    chk({tag, "_busy"},        busy,        0);
    chk({tag, "_frame_count"}, frame_count, 0);
  endtask

  // mode 0: i mod 256, mode 1: random, mode 2: mix of 0xFF, SYNC and random pixels
  task automatic run_frame(input int mode, input int junk);
    int s0;
    int k;
    logic [7:0] px;
    s0 = n_start;
    send(SYNC);
    for (int i = 0; i < NPIX; i++) begin
      case (mode)
        0:       px = 8'(i);
        1:       px = 8'($urandom);
        default: px = (i % 3 == 0) ? 8'hFF : ((i % 3 == 1) ? SYNC : 8'($urandom));
      endcase
      send(px);
      if ($urandom_range(7, 0) == 0) idle($urandom_range(3, 1));
    end
    for (int j = 0; j < junk; j++) send(8'($urandom));
    idle(1);
    k = 0;
    while (n_start == s0 && k < 60) begin @(negedge clk); #1; k++; end
    chk("inf_start_pulse_count", n_start, s0 + 1);
    k = 0;
    while (busy !== 1'b0 && k < 200) begin @(negedge clk); #1; k++; end
    chk("busy_low_after_done", busy, 0);
    phase  = 0;
    exp_fc = (exp_fc + 1) % 256;
    chk("frame_count", frame_count, exp_fc);
    chk("write_queue_drained", exp_q.size(), 0);
    chk("rst_start_pairs", n_rst, n_start);
  endtask

  // Monitor: pops the scoreboard on every write and checks pulse ordering.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (img_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %0d, required no write (cycle %0d)",
                   img_waddr, img_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", img_waddr, e.addr);
          chk("wr_data", img_wdata, e.data);
          chk("wr_edge", cyc, e.edge_n);
        end
        last_we_edge = cyc;
      end
      if (inf_rst === 1'b1) begin
        n_rst++;
        rst_edge = cyc;
        chk("inf_rst_after_last_write", cyc, last_we_edge + 1);
      end
      if (inf_start === 1'b1) begin
        n_start++;
        chk("inf_start_after_inf_rst", cyc, rst_edge + 1);
        chk("inf_start_exclusive", {inf_rst, img_we}, 0);
      end
      if (frame_err === 1'b1) begin
        n_err++;
        err_edge = cyc;
      end
    end
  end

  // Inference core model: done rises some cycles after start, falls on its reset.
  initial begin
    int cd;
    cd = 0;
    forever begin
      @(negedge clk);
      if (rst || inf_rst) begin
        inf_done = 1'b0;
        cd = 0;
      end else if (inf_start) begin
        cd = $urandom_range(40, 20);
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) inf_done = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int e0;
    int k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("reset");

    // Counting pattern, then junk bytes while inference runs.
    run_frame(0, 5);
    // Saturated and sync-valued pixels inside a frame.
    run_frame(2, 0);

    // Garbage before sync is discarded.
    send(8'h12);
    send(8'h55);
    idle(2);
    run_frame(1, 0);

    // Timeout abort after a partial frame.
    s0 = n_start;
    e0 = n_err;
    send(SYNC);
    for (int i = 0; i < 10; i++) send(8'($urandom));
    idle(1);
    k = 0;
    while (n_err == e0 && k < 150) begin @(negedge clk); #1; k++; end
    chk("frame_err_count", n_err, e0 + 1);
    chk("frame_err_latency", err_edge - last_byte_edge, TMO);
    @(negedge clk); #1;
    chk("frame_err_one_cycle", frame_err, 0);
    chk("busy_after_timeout", busy, 0);
    chk("no_start_after_timeout", n_start, s0);
    chk("frame_count_after_timeout", frame_count, exp_fc);
    chk("timeout_queue_drained", exp_q.size(), 0);
    phase = 0;

    // Reset in the middle of a frame.
    e0 = n_err;
    s0 = n_start;
    send(SYNC);
    for (int i = 0; i < 400; i++) send(8'($urandom));
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    phase  = 0;
    exp_fc = 0;
    chk_reset_outputs("midframe_reset");
    chk("no_err_on_reset", n_err, e0);
    chk("no_start_on_reset", n_start, s0);
    run_frame(1, 0);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
